// File: rtl/clk_rst_gen_pkg.sv
// clk_rst_gen shared types and defaults.
// Build option: CLK_RST_GEN_UART_LOOPBACK_EN adds a uart loopback input.
package clk_rst_gen_pkg;

    localparam int   PERIOD_W_DEF   = 32;
    localparam int   MIN_PERIOD_DEF = 2;
    localparam logic UART_IDLE      = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } gen_state_t;

endpackage

// File: rtl/clk_rst_gen_divider.sv
// Programmable slow-clock divider: period latch, phase FSM,
// registered gen_clk / gen_tick / running.
module clk_rst_gen_divider
    import clk_rst_gen_pkg::*;
#(
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run_clock,
    input  logic [PERIOD_W-1:0] clock_period,
    output logic                gen_clk,
    output logic                gen_tick,
    output logic                running
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    gen_state_t          state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] half;
    logic [PERIOD_W-1:0] req;
    logic                boundary;
    logic                start;
    logic                stop;

    assign req      = (clock_period < MIN_P) ? MIN_P : clock_period;
    // cnt is the 1-based position inside the current period
    assign boundary = (state == IDLE) || ((state == LOW) && (cnt == period));
    assign start    = boundary && run_clock;
    assign stop     = boundary && !run_clock;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            period   <= '0;
            half     <= '0;
            gen_clk  <= 1'b0;
            gen_tick <= 1'b0;
            running  <= 1'b0;
        end else begin
            gen_tick <= 1'b0;
            unique case (1'b1)
                start: begin
                    state    <= HIGH;
                    cnt      <= PERIOD_W'(1);
                    period   <= req;
                    half     <= req >> 1;
                    gen_clk  <= 1'b1;
                    gen_tick <= 1'b1;
                    running  <= 1'b1;
                end
                stop: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    gen_clk <= 1'b0;
                    running <= 1'b0;
                end
                (state == HIGH): begin
                    cnt <= cnt + PERIOD_W'(1);
                    if (cnt == half) begin
                        state   <= LOW;
                        gen_clk <= 1'b0;
                    end
                end
                default: begin
                    cnt <= cnt + PERIOD_W'(1);
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_rst_gen.sv
// Clock/reset/serial-pad glue: slow clock, tick-counted reset, uart_rx pad.
// Build option: CLK_RST_GEN_UART_LOOPBACK_EN adds input loopback.
module clk_rst_gen
    import clk_rst_gen_pkg::*;
#(
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int RST_CYCLES = 1,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run_clock,
    input  logic [PERIOD_W-1:0] clock_period,
    output logic                gen_clk,
    output logic                gen_tick,
    output logic                gen_rst,
    output logic                running,
    input  logic                uart_tx,
    input  logic                uart_rx_drv,
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
    input  logic                loopback,
`endif
    output logic                uart_rx
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES);

    logic [7:0] rst_cnt;
    logic       rx_src;

    clk_rst_gen_divider #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_divider (
        .clock        (clock),
        .reset        (reset),
        .run_clock    (run_clock),
        .clock_period (clock_period),
        .gen_clk      (gen_clk),
        .gen_tick     (gen_tick),
        .running      (running)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            gen_rst <= 1'b1;
            rst_cnt <= '0;
        end else if (gen_rst && gen_tick) begin
            rst_cnt <= rst_cnt + 8'd1;
            if (rst_cnt + 8'd1 == RST_LAST) begin
                gen_rst <= 1'b0;
            end
        end
    end

`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
    assign rx_src = loopback ? uart_tx : uart_rx_drv;
`else
    logic unused_tx;
    assign unused_tx = uart_tx;
    assign rx_src    = uart_rx_drv;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            uart_rx <= UART_IDLE;
        end else begin
            uart_rx <= gen_rst ? UART_IDLE : rx_src;
        end
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Randomized bench for clk_rst_gen with a period-position reference model.
module tb_clk_rst_gen;

    localparam int PW    = 32;
    localparam int RST_N = 1;

    logic          clock        = 1'b0;
    logic          reset        = 1'b1;
    logic          run_clock    = 1'b0;
    logic [PW-1:0] clock_period = '0;
    logic          uart_tx      = 1'b1;
    logic          uart_rx_drv  = 1'b1;
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
    logic          loopback     = 1'b0;
`endif
    logic gen_clk, gen_tick, gen_rst, running, uart_rx;

    int vecs  = 0;
    int errs  = 0;
    int cyc_n = 0;

    // reference model: position inside the current period
    bit m_act  = 0;
    bit m_tick = 0;
    bit m_rst  = 1;
    bit m_uart = 1;
    int m_pos  = 0;
    int m_p    = 0;
    int m_ticks = 0;

    logic [4:0] obs;
    assign obs = {gen_clk, gen_tick, running, gen_rst, uart_rx};

    clk_rst_gen #(
        .PERIOD_W   (PW),
        .RST_CYCLES (RST_N),
        .MIN_PERIOD (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run_clock    (run_clock),
        .clock_period (clock_period),
        .gen_clk      (gen_clk),
        .gen_tick     (gen_tick),
        .gen_rst      (gen_rst),
        .running      (running),
        .uart_tx      (uart_tx),
        .uart_rx_drv  (uart_rx_drv),
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
        .loopback     (loopback),
`endif
        .uart_rx      (uart_rx)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] expv();
        logic hi;
        hi = m_act && (m_pos < m_p / 2);
        return {hi, m_tick, m_act, m_rst, m_uart};
    endfunction

    task automatic model_step();
        bit   bnd;
        logic src;
        src = uart_rx_drv;
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
        if (loopback) src = uart_tx;
`endif
        if (reset) begin
            m_act = 0; m_pos = 0; m_p = 0; m_tick = 0;
            m_rst = 1; m_ticks = 0; m_uart = 1;
        end else begin
            m_uart = m_rst ? 1'b1 : src;
            if (m_tick && m_rst) begin
                m_ticks++;
                if (m_ticks == RST_N) m_rst = 0;
            end
            bnd = !m_act || (m_pos + 1 == m_p);
            if (bnd) begin
                m_tick = run_clock;
                m_act  = run_clock;
                m_pos  = 0;
                if (run_clock)
                    m_p = (clock_period < 2) ? 2 : int'(clock_period);
            end else begin
                m_tick = 0;
                m_pos++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        cyc_n++;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run_clock = 1'b1;
        repeat (2) begin
            cyc();
            vecs++;
            if (obs !== 5'b00011) begin
                errs++;
                $display("FAIL reset cyc=%0d got=%b want=%b", cyc_n, obs, 5'b00011);
            end
        end
    endtask

    task automatic test_period10();
        int hi = 0;
        int tk = 0;
        reset = 1'b0;
        run_clock = 1'b1;
        clock_period = 10;
        for (int i = 0; i < 45; i++) begin
            uart_rx_drv = 1'($urandom);
            cyc();
            hi += int'(gen_clk);
            tk += int'(gen_tick);
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL p10 cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
        vecs++;
        if (hi != 25 || tk != 5) begin
            errs++;
            $display("FAIL p10_counts got hi=%0d tk=%0d want hi=25 tk=5", hi, tk);
        end
    endtask

    task automatic test_small_periods();
        int hi = 0;
        clock_period = 3;
        for (int i = 0; i < 36; i++) begin
            if (i == 14) clock_period = 0;
            if (i == 25) clock_period = 1;
            cyc();
            if (i >= 28) hi += int'(gen_clk);
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL small cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
        vecs++;
        if (hi != 4) begin
            errs++;
            $display("FAIL clamp_duty got hi=%0d want 4", hi);
        end
    endtask

    task automatic test_mid_change();
        int tk[$];
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        clock_period = 10;
        run_clock = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) clock_period = 4;
            cyc();
            if (gen_tick) tk.push_back(k);
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL midchg cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
        vecs++;
        if (tk.size() < 3 || tk[0] != 1 || tk[1] != 11 || tk[2] != 15) begin
            errs++;
            $display("FAIL midchg_ticks got n=%0d want ticks at 1,11,15",
                     tk.size());
        end
    endtask

    task automatic test_run_drop();
        int hi = 0;
        int tk = 0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        clock_period = 10;
        run_clock = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 2) run_clock = 1'b0;
            hi += int'(gen_clk);
            if (k > 1) tk += int'(gen_tick);
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL rundrop cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
        vecs++;
        if (hi != 5 || tk != 0 || running !== 1'b0) begin
            errs++;
            $display("FAIL rundrop_end got hi=%0d tk=%0d run=%b want 5 0 0",
                     hi, tk, running);
        end
    endtask

    task automatic test_reset_mid();
        run_clock = 1'b1;
        clock_period = 6;
        repeat (8) begin
            cyc();
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL rstmid_pre cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
        reset = 1'b1;
        cyc();
        vecs++;
        if (obs !== 5'b00011) begin
            errs++;
            $display("FAIL rstmid cyc=%0d got=%b want=%b", cyc_n, obs, 5'b00011);
        end
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            vecs++;
            if (obs !== expv() || (k == 2 && gen_rst !== 1'b0)) begin
                errs++;
                $display("FAIL rstmid_post cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
    endtask

    task automatic test_uart();
        logic [3:0] pat;
        pat = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            uart_rx_drv = pat[i];
            cyc();
            vecs++;
            if (uart_rx !== pat[i] || obs !== expv()) begin
                errs++;
                $display("FAIL uart_pat cyc=%0d got=%b want=%b", cyc_n, uart_rx, pat[i]);
            end
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run_clock = 1'b0;
        for (int i = 0; i < 8; i++) begin
            uart_rx_drv = 1'(i & 1);
            cyc();
            vecs++;
            if (uart_rx !== 1'b1 || obs !== expv()) begin
                errs++;
                $display("FAIL uart_held cyc=%0d got=%b want=1", cyc_n, uart_rx);
            end
        end
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
        run_clock = 1'b1;
        clock_period = 4;
        repeat (3) cyc();
        loopback = 1'b1;
        uart_rx_drv = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            uart_tx = ~pat[i];
            cyc();
            vecs++;
            if (uart_rx !== ~pat[i] || obs !== expv()) begin
                errs++;
                $display("FAIL loopback cyc=%0d got=%b want=%b", cyc_n, uart_rx, ~pat[i]);
            end
        end
        loopback = 1'b0;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) run_clock = ~run_clock;
            clock_period = PW'($urandom_range(0, 12));
            uart_rx_drv  = 1'($urandom);
            uart_tx      = 1'($urandom);
`ifdef CLK_RST_GEN_UART_LOOPBACK_EN
            loopback     = 1'($urandom);
`endif
            cyc();
            vecs++;
            if (obs !== expv()) begin
                errs++;
                $display("FAIL random cyc=%0d got=%b want=%b", cyc_n, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_period10();
        test_small_periods();
        test_mid_change();
        test_run_drop();
        test_reset_mid();
        test_uart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/clk_rst_gen.md
Name: clk_rst_gen

Overview:
- Synthesizable clock/reset/serial-pad glue block for the UART/Wishbone verification top.
- Derives a programmable, gateable slow clock from the single system clock.
- Sequences a downstream reset pulse that is synchronous to that slow clock.
- Drives the DUT UART receive pad from a bench source, idling at mark (1).

Parameters:
- PERIOD_W, 32: width of clock_period.
- RST_CYCLES, 1: number of gen_clk rising edges after reset release for which gen_rst stays high. Range 1..255.
- MIN_PERIOD, 2: smallest legal gen_clk period in clock cycles; smaller requests are clamped up to this value.

Ports:
- clock, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- run_clock, input, 1: enables gen_clk generation.
- clock_period, input, PERIOD_W: requested gen_clk period in clock cycles.
- gen_clk, output, 1: generated clock, driven from a register.
- gen_tick, output, 1: one-cycle pulse, high in the same cycle gen_clk goes 0 to 1.
- gen_rst, output, 1: downstream reset, active-high.
- running, output, 1: a gen_clk period is in progress.
- uart_tx, input, 1: DUT transmit pad (stx).
- uart_rx_drv, input, 1: bench-driven serial data.
- uart_rx, output, 1: DUT receive pad (srx), driven from a register.

Behaviour:
- Reset values (next edge with reset=1): gen_clk=0, gen_tick=0, running=0, gen_rst=1, uart_rx=1, period counter=0, reset-edge counter=0.
- Period latch: P = max(clock_period, MIN_PERIOD), captured only at the start of each period. A change mid-period takes effect at the next period.
- Each period lasts P clocks. gen_clk is high for H = floor(P/2) clocks, then low for P-H clocks.
  - P=10 gives 5 high / 5 low.
  - P=3 gives 1 high / 2 low.
- States: IDLE, HIGH, LOW.
  - IDLE to HIGH: run_clock=1 sampled in IDLE. gen_clk=1 and gen_tick=1 on the next cycle (1-cycle start latency).
  - HIGH to LOW: after H cycles.
  - LOW to HIGH: after the final low cycle, if run_clock=1. The new P is latched and gen_tick pulses.
  - LOW to IDLE: after the final low cycle, if run_clock=0.
- Deasserting run_clock never truncates a period. The current period always finishes, so there are no glitches or short pulses.
- running = 1 in HIGH and LOW, 0 in IDLE.
- gen_rst:
  - High while reset=1.
  - After reset release, it counts gen_tick pulses and deasserts in the cycle after the RST_CYCLES-th tick.
  - It stays high indefinitely if run_clock never rises.
- uart_rx:
  - Registered copy of uart_rx_drv (1-cycle latency).
  - Forced to 1 while gen_rst=1.
- Reset asserted mid-operation overrides everything. The next cycle shows reset values and the latched period is discarded.
- Simultaneous events:
  - reset beats run_clock.
  - A period-boundary tick and the RST_CYCLES-th tick in the same cycle is a single event.

Optional Feature:
- Macro: CLK_RST_GEN_UART_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, uart_rx is a registered copy of uart_tx instead of uart_rx_drv.
  - The gen_rst force-to-1 rule still applies.
- When undefined: no loopback port exists, and uart_rx always follows uart_rx_drv.

Decomposition:
- Package clk_rst_gen_pkg holds:
  - PERIOD_W and MIN_PERIOD defaults.
  - UART_IDLE = 1'b1.
  - The state enum {IDLE, HIGH, LOW}.
- One natural sub-module, clk_rst_gen_divider: the period counter, the state machine, and the gen_clk/gen_tick/running outputs.
- The top module adds the gen_rst sequencer and the uart_rx register.

Test Plan:
- Reset for 2 cycles, then run_clock=1 with clock_period=10:
  - gen_clk rises 1 cycle later, then 5 high / 5 low repeating.
  - gen_tick pulses every 10 cycles.
  - gen_rst falls the cycle after the first tick.
- clock_period=3, then 0, then 1:
  - Period 3 gives 1 high / 2 low.
  - Periods 0 and 1 are both clamped to 2, giving 1 high / 1 low.
- clock_period changed from 10 to 4 in mid-high phase:
  - The current period completes at 10 cycles.
  - The next period is 2 high / 2 low.
- run_clock dropped during the 2nd high cycle of a P=10 period:
  - The period finishes all 10 cycles.
  - gen_clk then stays 0, running=0, and no further ticks occur.
- reset asserted mid-period:
  - The next cycle gives gen_clk=0, gen_rst=1, uart_rx=1.
  - After release with run_clock=1, the sequence restarts and gen_rst clears after 1 tick.
- UART pad:
  - With gen_rst=0, uart_rx_drv pattern 1,0,1,1 appears on uart_rx delayed by exactly 1 cycle.
  - With gen_rst=1, uart_rx stays 1.
  - With the macro defined and loopback=1, uart_rx follows uart_tx delayed by 1 cycle.
